fp32_mat_vec_seq: RTL and testbench

- Sequencer that turns one 4x4 matrix times vec4 transform into four row-by-vector dot products.
- Streams the four row/vector operand pairs into an external fp32 dot-product pipeline, one pair per cycle.
- Reassembles the four scalar results into an output vec4 and buffers it behind a valid/ready output.
- Sits between the vertex fetch stage and the perspective-divide stage of the vertex transform path.

---
 rtl/fp32_pkg.sv | 9 +
 rtl/fp32_vec4_fifo.sv | 54 +++++
 rtl/fp32_mat_vec_seq.sv | 139 +++++++++++++
 tb/tb_fp32_mat_vec_seq.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32 vector/matrix types and constants for the vertex transform path
package fp32_pkg;
    typedef logic [31:0] fp32_t;
    typedef logic [3:0][31:0] vec4_t;
    typedef logic [3:0][3:0][31:0] mat4_t;
    typedef enum logic {IDLE, ISSUE} seq_state_t;
    localparam fp32_t FP32_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_ONE  = 32'h3F80_0000;
endpackage

// File: rtl/fp32_vec4_fifo.sv
// fp32_vec4_fifo: synchronous vec4 FIFO with occupancy count, simultaneous push/pop when full
module fp32_vec4_fifo
    import fp32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_push,
    input  vec4_t         i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output vec4_t         o_data,
    output logic [CW-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    vec4_t         r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_valid = r_count != '0;
    assign o_data  = r_mem[r_rp];
    assign o_count = r_count;

    // entry storage, written at the tail
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    // head/tail pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
            if (w_pop) r_rp <= (r_rp == LAST) ? '0 : r_rp + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: rtl/fp32_mat_vec_seq.sv
// fp32_mat_vec_seq: splits a 4x4 matrix * vec4 into four dot products and reassembles the result
module fp32_mat_vec_seq
    import fp32_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   mat_load_in,
    input  logic [3:0][3:0][31:0]  mat_in,
    output logic                   mat_ready_out,
    input  logic                   vec_valid_in,
    input  logic [3:0][31:0]       vec_in,
    output logic                   vec_ready_out,
    output logic                   dot_valid_out,
    output logic [3:0][31:0]       dot_a_out,
    output logic [3:0][31:0]       dot_b_out,
    input  logic                   dot_valid_in,
    input  logic [31:0]            dot_c_in,
    output logic                   vec_valid_out,
    output logic [3:0][31:0]       vec_out,
    input  logic                   vec_ready_in,
    output logic                   err_out
);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [1:0]       r_row;
    logic [1:0]       w_row_nxt;
    mat4_t            r_mat;
    vec4_t            r_vec;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    w_fifo_count;
    logic [CW:0]      w_used;
    logic [1:0]       r_idx;
    logic [2:0][31:0] r_asm;
    logic             r_err;
    logic             w_credit_ok;
    logic             w_vec_acc;
    logic             w_mat_acc;
    logic             w_res;
    logic             w_push;
    vec4_t            w_push_data;

    // vectors sitting in the FIFO plus those still in the dot pipeline share the FIFO space
    assign w_used      = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign w_credit_ok = w_used < (CW + 1)'(OUT_DEPTH);
    assign w_vec_acc   = vec_valid_in && vec_ready_out;
    assign w_mat_acc   = mat_load_in && mat_ready_out;
    assign w_res       = dot_valid_in && (r_inflight != '0);
    assign w_push      = w_res && (r_idx == 2'd3);
    assign w_push_data = {dot_c_in, r_asm[2], r_asm[1], r_asm[0]};
    assign dot_a_out   = r_mat[r_row];
    assign dot_b_out   = r_vec;
    assign err_out     = r_err;

    // issue FSM: next state, row and handshakes; row 3 may chain straight into the next vector
    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        mat_ready_out = 1'b0;
        vec_ready_out = 1'b0;
        dot_valid_out = 1'b0;
        if (r_state == IDLE) begin
            mat_ready_out = r_inflight == '0;
            vec_ready_out = w_credit_ok && !mat_load_in;
        end else begin
            dot_valid_out = 1'b1;
            vec_ready_out = (r_row == 2'd3) && w_credit_ok;
            w_row_nxt     = r_row + 2'd1;
            w_state_nxt   = (r_row == 2'd3) ? IDLE : ISSUE;
        end
        if (vec_valid_in && vec_ready_out) begin
            w_state_nxt = ISSUE;
            w_row_nxt   = 2'd0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_row   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    // matrix and current vector operand registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_mat <= '0;
            r_vec <= '0;
        end else begin
            if (w_mat_acc) r_mat <= mat_in;
            if (w_vec_acc) r_vec <= vec_in;
        end
    end

    // vectors accepted but not yet written to the FIFO
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_vec_acc) - CW'(w_push);
        end
    end

    // result collector; results with nothing in flight are dropped and flagged
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_idx <= 2'd0;
            r_asm <= {3{FP32_ZERO}};
            r_err <= 1'b0;
        end else begin
            if (w_res) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx != 2'd3) r_asm[r_idx] <= dot_c_in;
            end
            if (dot_valid_in && (r_inflight == '0)) r_err <= 1'b1;
        end
    end

    fp32_vec4_fifo #(
        .DEPTH(OUT_DEPTH),
        .CW   (CW)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_push (w_push),
        .i_data (w_push_data),
        .i_pop  (vec_ready_in),
        .o_valid(vec_valid_out),
        .o_data (vec_out),
        .o_count(w_fifo_count)
    );
endmodule

// File: tb/tb_fp32_mat_vec_seq.sv
// tb_fp32_mat_vec_seq: directed bench with a 2-cycle fp32 dot pipeline model
module tb_fp32_mat_vec_seq;
    import fp32_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        mat_load_in = 1'b0;
    mat4_t       mat_in = '0;
    logic        mat_ready_out;
    logic        vec_valid_in = 1'b0;
    vec4_t       vec_in = '0;
    logic        vec_ready_out;
    logic        dot_valid_out;
    vec4_t       dot_a_out;
    vec4_t       dot_b_out;
    logic        dot_valid_in;
    logic [31:0] dot_c_in;
    logic        vec_valid_out;
    vec4_t       vec_out;
    logic        vec_ready_in = 1'b1;
    logic        err_out;

    logic             spur = 1'b0;
    logic [1:0]       pv;
    logic [1:0][31:0] pc;
    int               checks = 0;
    int               errors = 0;
    vec4_t            got[$];
    vec4_t            rows[$];
    int               acc_cnt = 0;
    int               dot_cnt = 0;
    int               run = 0;
    int               max_run = 0;

    fp32_mat_vec_seq #(.OUT_DEPTH(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .mat_load_in  (mat_load_in),
        .mat_in       (mat_in),
        .mat_ready_out(mat_ready_out),
        .vec_valid_in (vec_valid_in),
        .vec_in       (vec_in),
        .vec_ready_out(vec_ready_out),
        .dot_valid_out(dot_valid_out),
        .dot_a_out    (dot_a_out),
        .dot_b_out    (dot_b_out),
        .dot_valid_in (dot_valid_in),
        .dot_c_in     (dot_c_in),
        .vec_valid_out(vec_valid_out),
        .vec_out      (vec_out),
        .vec_ready_in (vec_ready_in),
        .err_out      (err_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic real fp2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2fp(input real v);
        logic s;
        int   e;
        if (v == 0.0) return 32'h0;
        e = 127;
        s = v < 0.0;
        if (s) v = -v;
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0) begin v = v * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((v - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] dot_fn(input vec4_t a, input vec4_t b);
        real acc = 0.0;
        for (int i = 0; i < 4; i++) acc = acc + fp2r(a[i]) * fp2r(b[i]);
        return r2fp(acc);
    endfunction

    // external dot-product pipeline, two cycles, sharing the design reset
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pv <= '0;
            pc <= '0;
        end else begin
            pv <= {pv[0], dot_valid_out};
            pc <= {pc[0], dot_fn(dot_a_out, dot_b_out)};
        end
    end
    assign dot_valid_in = pv[1] | spur;
    assign dot_c_in     = pc[1];

    // observers on the falling edge
    always @(negedge clk_in) begin
        if (vec_valid_out && vec_ready_in) got.push_back(vec_out);
        if (vec_valid_in && vec_ready_out) acc_cnt++;
        if (dot_valid_out) begin
            rows.push_back(dot_a_out);
            dot_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send(input vec4_t v);
        int n = 0;
        vec_valid_in = 1'b1;
        vec_in = v;
        @(negedge clk_in);
        while (!vec_ready_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk("send_timeout", 128'(n >= 50), 0);
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got.size() < n && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        chk("out_timeout", 128'(k >= 100), 0);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        mat4_t       id_m;
        mat4_t       one_m;
        vec4_t       v1234;
        vec4_t       v5678;
        logic [31:0] fk [8];
        int          base;
        int          rb;
        int          d0;
        int          a0;
        int          n;
        fk = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                id_m[r][c]  = (r == c) ? FP32_ONE : FP32_ZERO;
                one_m[r][c] = FP32_ONE;
            end
        v1234 = {fk[3], fk[2], fk[1], fk[0]};
        v5678 = {fk[7], fk[6], fk[5], fk[4]};

        tick(2);
        chk("rst_vec_valid", vec_valid_out, 0);
        chk("rst_dot_valid", dot_valid_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_vec_out", vec_out, 0);
        rst_in = 1'b1;
        tick(1);
        chk("idle_mat_ready", mat_ready_out, 1);

        // identity transform
        mat_in = id_m;
        mat_load_in = 1'b1;
        tick(1);
        mat_load_in = 1'b0;
        base = got.size();
        rb = rows.size();
        d0 = dot_cnt;
        send(v1234);
        vec_valid_in = 1'b0;
        wait_got(base + 1);
        chk("id_result", got[base], v1234);
        chk("id_dot_pulses", dot_cnt - d0, 4);
        for (int i = 0; i < 4; i++) chk("id_row", rows[rb + i], id_m[i]);

        // load and vector together: load wins, vector follows using the new matrix
        base = got.size();
        a0 = acc_cnt;
        mat_in = one_m;
        mat_load_in = 1'b1;
        vec_valid_in = 1'b1;
        vec_in = v1234;
        @(negedge clk_in);
        chk("same_mat_ready", mat_ready_out, 1);
        chk("same_vec_blocked", vec_ready_out, 0);
        @(posedge clk_in);
        #1;
        mat_load_in = 1'b0;
        @(negedge clk_in);
        chk("same_vec_ready", vec_ready_out, 1);
        @(posedge clk_in);
        #1;
        vec_valid_in = 1'b0;
        chk("same_acc", acc_cnt - a0, 1);
        wait_got(base + 1);
        chk("ones_result", got[base], {4{32'h41200000}});

        // eight back-to-back vectors
        base = got.size();
        d0 = dot_cnt;
        for (int k = 0; k < 8; k++) send({96'h0, fk[k]});
        vec_valid_in = 1'b0;
        wait_got(base + 8);
        chk("b2b_max_run", max_run, 32);
        chk("b2b_dot_pulses", dot_cnt - d0, 32);
        for (int k = 0; k < 8; k++) chk("b2b_result", got[base + k], {4{fk[k]}});

        // output stalled: credit stops after two vectors
        base = got.size();
        a0 = acc_cnt;
        vec_ready_in = 1'b0;
        send({96'h0, fk[0]});
        send({96'h0, fk[1]});
        vec_in = {96'h0, fk[2]};
        tick(20);
        chk("cap_acc", acc_cnt - a0, 2);
        chk("cap_ready", vec_ready_out, 0);
        chk("cap_valid", vec_valid_out, 1);
        chk("cap_head", vec_out, {4{fk[0]}});
        tick(3);
        chk("cap_hold", vec_out, {4{fk[0]}});
        chk("cap_no_pop", got.size(), base);
        vec_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        vec_ready_in = 1'b0;
        chk("cap_ready_after_pop", vec_ready_out, 1);
        chk("cap_head2", vec_out, {4{fk[1]}});
        tick(1);
        vec_valid_in = 1'b0;
        chk("cap_acc3", acc_cnt - a0, 3);
        vec_ready_in = 1'b1;
        wait_got(base + 3);
        for (int k = 0; k < 3; k++) chk("cap_order", got[base + k], {4{fk[k]}});

        // load requested while a vector is in flight
        base = got.size();
        send(v1234);
        vec_valid_in = 1'b0;
        mat_in = id_m;
        mat_load_in = 1'b1;
        chk("busy_issue_mat_ready", mat_ready_out, 0);
        tick(4);
        chk("busy_drain_dot", dot_valid_out, 0);
        chk("busy_drain_mat_ready", mat_ready_out, 0);
        n = 0;
        @(negedge clk_in);
        while (!mat_ready_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk("mat_wait_timeout", 128'(n >= 50), 0);
        @(posedge clk_in);
        #1;
        mat_load_in = 1'b0;
        wait_got(base + 1);
        chk("busy_old_matrix", got[base], {4{32'h41200000}});
        send(v1234);
        vec_valid_in = 1'b0;
        wait_got(base + 2);
        chk("busy_new_matrix", got[base + 1], v1234);

        // spurious dot result
        base = got.size();
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        chk("spur_err", err_out, 1);
        tick(3);
        chk("spur_no_push", got.size(), base);
        chk("spur_no_valid", vec_valid_out, 0);
        send(v5678);
        vec_valid_in = 1'b0;
        wait_got(base + 1);
        chk("spur_next_result", got[base], v5678);
        chk("spur_err_sticky", err_out, 1);

        // reset in the middle of issue
        send(v1234);
        vec_valid_in = 1'b0;
        chk("mid_issue", dot_valid_out, 1);
        rst_in = 1'b0;
        #1;
        chk("mid_rst_dot", dot_valid_out, 0);
        chk("mid_rst_valid", vec_valid_out, 0);
        chk("mid_rst_err", err_out, 0);
        chk("mid_rst_a", dot_a_out, 0);
        tick(2);
        rst_in = 1'b1;
        tick(1);
        base = got.size();
        send(v1234);
        vec_valid_in = 1'b0;
        wait_got(base + 1);
        chk("post_rst_zero_matrix", got[base], 0);
        chk("post_rst_err", err_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
